mult_div_sequencer: RTL and testbench
=====================================

// Module: mult_div_sequencer
// PURPOSE
//  Multi-cycle HI/LO unit controller for the 5-stage MIPS pipeline: runs MULT/MULTU/DIV/DIVU iteratively
//  (1 bit per cycle) and owns the HI/LO registers. It raises stall_req towards the hazard unit while an
//  ID-stage instruction touches HI/LO before the result exists. Sits beside the EX-stage ALU.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH
// PORTS
//  Clk             in   1      clock; all state updates on rising edge
//  Reset           in   1      synchronous, active-high
//  start           in   1      EX holds MULT/MULTU/DIV/DIVU this cycle (already flush-qualified)
//  op              in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  A, B            in   WIDTH  rs / rt operands (forwarded values)
//  ID_Instruction  in   32     instruction currently in ID
//  mthi_we, mtlo_we in  1      MTHI/MTLO write strobes from EX
//  mt_data         in   WIDTH  MTHI/MTLO write data
//  HI, LO          out  WIDTH  architectural HI/LO (registered)
//  busy            out  1      state != IDLE
//  done            out  1      one-cycle pulse in the cycle after HI/LO take a new result
//  stall_req       out  1      combinational; ORed into PCoff/IFID_writeOff/stall_mux by hazard unit
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, busy=0, done=0, iteration counter=0. Reset mid-operation aborts it, no write.
//  FSM: IDLE -> MUL|DIV on start (op[1]) -> FIX -> IDLE.
//   IDLE: on start, latch |A|,|B| (abs only when signed op), sign_a, sign_b, op; count=0.
//   MUL: shift-add, 2*WIDTH-bit accumulator; WIDTH cycles, then FIX.
//   DIV: restoring divide, 1 quotient bit/cycle; WIDTH cycles, then FIX.
//   FIX: sign correction, write HI/LO at end of cycle; next state IDLE, done=1 in that IDLE cycle.
//  Latency: start sampled at edge t -> HI/LO updated at edge t+WIDTH+1; busy high for WIDTH+1 cycles.
//  Arithmetic: MULT product negated if sign_a^sign_b; {HI,LO}=64-bit product. DIV: LO=quotient, negated if
//   sign_a^sign_b; HI=remainder, negated if sign_a. 0x80000000/-1 (DIV) -> LO=0x80000000, HI=0 (wrap).
//   Divide by zero (B==0, both DIV/DIVU): LO=all ones, HI=A as latched raw (unsigned bits). No exception.
//  stall_req = (busy | start) & ID_Instruction is R-type (opcode 0) with funct in
//   {MFHI,MTHI,MFLO,MTLO,MULT,MULTU,DIV,DIVU}. No stall for other instructions; pipeline runs freely.
//  start while busy: illegal (stall prevents it); ignored, operation in flight unaffected.
//  mthi_we/mtlo_we: applied in IDLE only; ignored while busy. Same cycle as start: mt write lands,
//   operation starts; its FIX write later overwrites HI/LO.
//  FIX write and Reset in same cycle: Reset wins.
// STRUCTURE
//  Shared package/header (mips_defs): funct codes MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13,
//   MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B; op encodings MD_MULT..MD_DIVU; state encodings.
//  One sub-module: mdu_iter_datapath (accumulator/remainder registers, one shift-add or shift-subtract
//   step per enable, step select from FSM). FSM, counter, HI/LO, sign fix and stall decode stay at top.
// TESTING
//  1 MULT A=-3 (0xFFFFFFFD), B=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; done pulses once.
//  2 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DIVU 100/7 -> LO=14, HI=2.
//  3 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0;
//    DIV 5/0 -> LO=0xFFFFFFFF, HI=5.
//  4 MFLO in ID at start cycle and through busy -> stall_req=1 for 33 cycles, drops the cycle done=1;
//    ADD in ID while busy -> stall_req=0.
//  5 Reset asserted at iteration 10 of DIV -> next cycle busy=0, HI=LO=0, no done pulse;
//    new MULT 2*3 afterwards -> LO=6.
//  6 mthi_we with mt_data=0x1234 in IDLE -> HI=0x1234 next cycle; mtlo_we while busy -> LO unchanged.

Source files
------------

// File: rtl/mult_div_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes, op/state/step encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_div_sequencer_pkg;

    // R-type funct codes that read or write HI/LO
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MTHI   = 6'h11;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MTLO   = 6'h13;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    // op[1] selects divide, op[0] selects unsigned
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_t;

    // Per-cycle command to the iterative datapath
    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_LOAD = 2'b01,
        STEP_MUL  = 2'b10,
        STEP_DIV  = 2'b11
    } md_step_t;

    // True when the instruction is an R-type that depends on or modifies HI/LO
    function automatic logic touches_hilo(input logic [5:0] opcode, input logic [5:0] funct);
        logic hit;
        hit = 1'b0;
        if (opcode == OPC_RTYPE) begin
            case (funct)
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: hit = 1'b1;
                default:                            hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

endpackage

// File: rtl/mult_div_sequencer_datapath.sv
// Iterative magnitude datapath: one shift-add (multiply) or shift-subtract (restoring divide) step per command.
// Latency: one step per cycle; results valid WIDTH steps after LOAD.
// Backpressure: none; STEP_HOLD freezes all registers.
module mult_div_sequencer_datapath
    import mult_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  md_step_t         i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // r_acc_hi: product high half / partial remainder
    // r_acc_lo: multiplier being consumed / quotient being built (dividend shifted out of the top)
    // r_opnd:   multiplicand / divisor
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic             w_unused_top;

    assign w_addend = r_acc_lo[0] ? r_opnd : '0;
    assign w_sum    = {1'b0, r_acc_hi} + {1'b0, w_addend};
    assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_opnd};
    assign w_borrow = w_diff[WIDTH+1];

    // The remainder is always below the divisor, so these top bits are zero whenever they would be kept
    assign w_unused_top = w_diff[WIDTH] ^ w_shift[WIDTH];

    // Load operands, then advance one multiply or divide step per command
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
        end else begin
            case (i_step)
                STEP_LOAD: begin
                    r_acc_hi <= '0;
                    r_acc_lo <= i_a;
                    r_opnd   <= i_b;
                end
                STEP_MUL: begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                end
                STEP_DIV: begin
                    r_acc_hi <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_borrow};
                end
                default: ;
            endcase
        end
    end

    assign o_hi = r_acc_hi;
    assign o_lo = r_acc_lo;

endmodule

// File: rtl/mult_div_sequencer.sv
// HI/LO unit: iterative MULT/MULTU/DIV/DIVU, owns HI/LO, requests pipeline stall on HI/LO hazards.
// Latency: start sampled at edge t -> HI/LO written at edge t+WIDTH+1, done pulses the following cycle.
// Backpressure: none accepted; stall_req holds ID while busy, start/mt writes while busy are ignored.
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [31:0]      ID_Instruction,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    localparam int             CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_is_div;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_a_raw;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    md_state_t        w_next_state;
    md_step_t         w_step;
    logic             w_idle;
    logic             w_start_ok;
    logic             w_signed_op;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_last_iter;
    logic [WIDTH-1:0] w_dp_hi;
    logic [WIDTH-1:0] w_dp_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_id_hilo;
    logic             w_id_unused;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_start_ok  = start & w_idle;
    assign w_signed_op = ~op[0];
    assign w_sign_a    = w_signed_op & A[WIDTH-1];
    assign w_sign_b    = w_signed_op & B[WIDTH-1];
    assign w_abs_a     = w_sign_a ? (~A + 1'b1) : A;
    assign w_abs_b     = w_sign_b ? (~B + 1'b1) : B;
    assign w_last_iter = (r_count == LAST_ITER);

    mult_div_sequencer_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_step  (w_step),
        .i_a     (w_abs_a),
        .i_b     (w_abs_b),
        .o_hi    (w_dp_hi),
        .o_lo    (w_dp_lo)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and datapath step select
    always_comb begin
        w_next_state = r_state;
        w_step       = STEP_HOLD;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_step       = STEP_LOAD;
                    w_next_state = op[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                w_step = STEP_MUL;
                if (w_last_iter) w_next_state = ST_FIX;
            end
            ST_DIV: begin
                w_step = STEP_DIV;
                if (w_last_iter) w_next_state = ST_FIX;
            end
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Iteration counter: cleared on start, advances once per datapath step
    always_ff @(posedge Clk) begin
        if (Reset)                                    r_count <= '0;
        else if (w_start_ok)                          r_count <= '0;
        else if (r_state == ST_MUL || r_state == ST_DIV) r_count <= r_count + 1'b1;
        else                                          r_count <= '0;
    end

    // Capture operation attributes needed for the final sign fix and divide-by-zero result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_raw  <= '0;
            r_b_zero <= 1'b0;
        end else if (w_start_ok) begin
            r_is_div <= op[1];
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_a_raw  <= A;
            r_b_zero <= (B == '0);
        end
    end

    assign w_prod = {w_dp_hi, w_dp_lo};

    // Sign correction of the magnitude result; sign flags are already zero for unsigned ops
    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        if (!r_is_div) begin
            if (r_sign_a ^ r_sign_b) {w_res_hi, w_res_lo} = ~w_prod + 1'b1;
            else                     {w_res_hi, w_res_lo} = w_prod;
        end else if (r_b_zero) begin
            w_res_hi = r_a_raw;
            w_res_lo = '1;
        end else begin
            w_res_lo = (r_sign_a ^ r_sign_b) ? (~w_dp_lo + 1'b1) : w_dp_lo;
            w_res_hi = r_sign_a ? (~w_dp_hi + 1'b1) : w_dp_hi;
        end
    end

    // HI/LO: reset beats the FIX write; MTHI/MTLO only take effect while idle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == ST_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_idle) begin
            if (mthi_we) r_hi <= mt_data;
            if (mtlo_we) r_lo <= mt_data;
        end
    end

    // Completion pulse in the cycle after the result lands
    always_ff @(posedge Clk) begin
        if (Reset) r_done <= 1'b0;
        else       r_done <= (r_state == ST_FIX);
    end

    // Only opcode and funct matter for the hazard decode
    assign w_id_unused = |ID_Instruction[25:6];
    assign w_id_hilo   = touches_hilo(ID_Instruction[31:26], ID_Instruction[5:0]);

    assign HI        = r_hi;
    assign LO        = r_lo;
    assign busy      = ~w_idle;
    assign done      = r_done;
    assign stall_req = (busy | start) & w_id_hilo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer with a done-triggered scoreboard.
// Latency: expects HI/LO WIDTH+1 edges after start, done one cycle later.
// Backpressure: n/a.
module tb_mult_div_sequencer;

    localparam int W = 32;

    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_MFLO = 32'h0000_4012;
    localparam logic [31:0] I_ADD  = 32'h0109_5020;

    logic          Clk;
    logic          Reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [31:0]   ID_Instruction;
    logic          mthi_we;
    logic          mtlo_we;
    logic [W-1:0]  mt_data;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;
    logic          busy;
    logic          done;
    logic          stall_req;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    mult_div_sequencer #(.WIDTH(W)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .start          (start),
        .op             (op),
        .A              (A),
        .B              (B),
        .ID_Instruction (ID_Instruction),
        .mthi_we        (mthi_we),
        .mtlo_we        (mtlo_we),
        .mt_data        (mt_data),
        .HI             (HI),
        .LO             (LO),
        .busy           (busy),
        .done           (done),
        .stall_req      (stall_req)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected {HI,LO}
    always @(negedge Clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse with no pending result, HI=0x%0h LO=0x%0h", HI, LO);
            end else begin
                chk("hilo_result", {HI, LO}, exp_q.pop_front());
            end
        end
    end

    // Drive start for one cycle; optionally register the expected result
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push, output bit st_start);
        @(posedge Clk); #1;
        start = 1'b1; op = o; A = a; B = b;
        if (push) exp_q.push_back(exp);
        @(negedge Clk);
        st_start = stall_req;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    // Wait for done; lat counts from the edge that sampled start (that edge = 1)
    task automatic wait_done(output int lat, output int st_busy, output bit st_done);
        bit seen;
        seen    = 1'b0;
        lat     = 1;
        st_busy = 0;
        st_done = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge Clk);
            if (busy && stall_req) st_busy++;
            if (done) begin
                seen    = 1'b1;
                st_done = stall_req;
            end else begin
                @(posedge Clk); #1;
                lat++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles, busy=%0b", lat, busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        bit ss;
        bit sd;
        int lat;
        int sb;

        Reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        ID_Instruction = I_NOP; mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("reset_hi", HI, 0);
        chk("reset_lo", LO, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        ID_Instruction = I_MFLO;
        @(negedge Clk);
        chk("idle_mflo_no_stall", stall_req, 0);

        // MULT -3*7 with MFLO waiting in ID
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, ss);
        chk("stall_at_start", ss, 1);
        wait_done(lat, sb, sd);
        chk("latency", lat, W + 2);
        chk("stall_busy_cycles", sb, W + 1);
        chk("stall_at_done", sd, 0);
        @(negedge Clk);
        chk("done_single_pulse", done, 0);

        // Unrelated instruction in ID never stalls
        ID_Instruction = I_ADD;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, ss);
        chk("add_no_stall_start", ss, 0);
        wait_done(lat, sb, sd);
        chk("add_no_stall_busy", sb, 0);
        issue(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, ss);
        wait_done(lat, sb, sd);

        // Signed divide corners, signed multiply, divide by zero
        ID_Instruction = I_NOP;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, ss);
        wait_done(lat, sb, sd);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b1, ss);
        wait_done(lat, sb, sd);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, ss);
        wait_done(lat, sb, sd);
        issue(2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 64'd20, 1'b1, ss);
        wait_done(lat, sb, sd);
        issue(2'b11, 32'h8000_0005, 32'd0, 64'h8000_0005_FFFF_FFFF, 1'b1, ss);
        wait_done(lat, sb, sd);
        issue(2'b10, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, ss);
        wait_done(lat, sb, sd);

        // Reset at iteration 10 of a DIV aborts it without a write or done
        issue(2'b10, 32'd1000, 32'd3, 64'd0, 1'b0, ss);
        repeat (10) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", HI, 0);
        chk("abort_lo", LO, 0);
        chk("abort_done", done, 0);
        repeat (40) @(negedge Clk);
        issue(2'b00, 32'd2, 32'd3, 64'd6, 1'b1, ss);
        wait_done(lat, sb, sd);

        // MTHI while idle lands next cycle
        @(posedge Clk); #1;
        mthi_we = 1'b1; mt_data = 32'h0000_1234;
        @(posedge Clk); #1;
        mthi_we = 1'b0;
        @(negedge Clk);
        chk("mthi_idle_hi", HI, 32'h0000_1234);
        chk("mthi_idle_lo", LO, 32'd6);

        // MTLO and a stray start while busy are both ignored
        issue(2'b01, 32'h10, 32'h10, 64'h100, 1'b1, ss);
        mtlo_we = 1'b1; mt_data = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b11; A = 32'd1; B = 32'd1;
        @(posedge Clk); #1;
        mtlo_we = 1'b0; start = 1'b0;
        @(negedge Clk);
        chk("mtlo_busy_lo", LO, 32'd6);
        chk("mtlo_busy_still_busy", busy, 1);
        wait_done(lat, sb, sd);

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
